// File: rtl/cpu_defs.sv
// Shared CPU definitions: ALU one-hot op layout, divider iteration count,
// and a small two's-complement helper used by the divider.
// No ports; imported by alu, div_iter and the execute stage.
package cpu_defs;

  localparam int ALU_OP_W = 12;

  // Bit positions inside the one-hot ALU op vector.
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLT  = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_AND  = 4;
  localparam int OP_OR   = 5;
  localparam int OP_NOR  = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;

  localparam int DIV_ITER = 32;

  // Conditionally negate a 32-bit value.
  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU selected by a one-hot op vector.
// Ports: alu_op (one-hot), src1, src2 -> result. Shifts use src1[4:0] as the
// shift amount and src2 as the value; LUI places src2[15:0] in the upper half.
module alu
  import cpu_defs::*;
(
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [31:0]         src1,
  input  logic [31:0]         src2,
  output logic [31:0]         result
);

  logic [31:0] sum, diff, sra_res;
  logic        slt, sltu;

  always_comb begin
    sum     = src1 + src2;
    diff    = src1 - src2;
    slt     = $signed(src1) < $signed(src2);
    sltu    = src1 < src2;
    sra_res = $signed(src2) >>> src1[4:0];
    result  = ({32{alu_op[OP_ADD]}}  & sum)
            | ({32{alu_op[OP_SUB]}}  & diff)
            | ({32{alu_op[OP_SLT]}}  & {31'd0, slt})
            | ({32{alu_op[OP_SLTU]}} & {31'd0, sltu})
            | ({32{alu_op[OP_AND]}}  & (src1 & src2))
            | ({32{alu_op[OP_OR]}}   & (src1 | src2))
            | ({32{alu_op[OP_NOR]}}  & ~(src1 | src2))
            | ({32{alu_op[OP_XOR]}}  & (src1 ^ src2))
            | ({32{alu_op[OP_SLL]}}  & (src2 << src1[4:0]))
            | ({32{alu_op[OP_SRL]}}  & (src2 >> src1[4:0]))
            | ({32{alu_op[OP_SRA]}}  & sra_res)
            | ({32{alu_op[OP_LUI]}}  & {src2[15:0], 16'd0});
  end

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider, signed or unsigned, one bit per cycle.
// Ports: start (one-cycle pulse capturing a/b/is_signed), busy while iterating,
// done (one-cycle pulse with quotient/remainder valid; they hold until the next start).
module div_iter
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [5:0]  count;
  logic [31:0] rem_q, quo_q, div_q;
  logic        q_neg, r_neg;
  logic        a_neg, b_neg;
  logic [32:0] shifted, diff;
  logic [31:0] rem_nx, quo_nx;

  always_comb begin
    a_neg   = is_signed & a[31];
    b_neg   = is_signed & b[31];
    // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder.
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, div_q};
    if (diff[32]) begin
      rem_nx = shifted[31:0];
      quo_nx = {quo_q[30:0], 1'b0};
    end else begin
      rem_nx = diff[31:0];
      quo_nx = {quo_q[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= 6'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      div_q     <= 32'd0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= 32'd0;
      remainder <= 32'd0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy  <= 1'b1;
        count <= 6'd1;
        rem_q <= 32'd0;
        quo_q <= neg_if(a_neg, a);
        div_q <= neg_if(b_neg, b);
        q_neg <= a_neg ^ b_neg;
        r_neg <= a_neg;
      end else if (busy) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        if (count == 6'(DIV_ITER)) begin
          // Last iteration: register the sign-corrected result directly.
          busy      <= 1'b0;
          done      <= 1'b1;
          count     <= 6'd0;
          quotient  <= neg_if(q_neg, quo_nx);
          remainder <= neg_if(r_neg, rem_nx);
        end else begin
          count <= count + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches the ID bundle, computes the ALU or divider result,
// and issues the data SRAM request in the cycle the instruction moves to MEM.
// Ports: ID handshake (ready_go_id/allow_in), MEM handshake (ready_go/MEM_allow_in),
// latched bundle outputs, data SRAM request, and forward/load-use info for ID.
module exe_stage #(
  parameter int ALU_OP_W = cpu_defs::ALU_OP_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ready_go_id,
  output logic                allow_in,
  input  logic [31:0]         inst_from_id,
  input  logic [31:0]         pc_from_id,
  input  logic [ALU_OP_W-1:0] alu_op_from_id,
  input  logic [31:0]         src1_from_id,
  input  logic [31:0]         src2_from_id,
  input  logic                div_en_from_id,
  input  logic                div_signed_from_id,
  input  logic                div_rem_from_id,
  input  logic                reg_en_from_id,
  input  logic                mem_ld_from_id,
  input  logic                mem_st_from_id,
  input  logic [31:0]         st_data_from_id,
  input  logic [4:0]          dest_from_id,
  output logic                ready_go,
  input  logic                MEM_allow_in,
  output logic [31:0]         inst_exe,
  output logic [31:0]         pc_exe,
  output logic                reg_en,
  output logic                mem_ld,
  output logic [4:0]          dest,
  output logic [31:0]         exe_result,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_we,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata,
  output logic                valid,
  output logic [31:0]         forward_data_exe,
  output logic                exe_is_load
);

  logic [ALU_OP_W-1:0] alu_op_r;
  logic [31:0]         src1_r, src2_r, st_data_r, alu_result;
  logic                div_en_r, div_signed_r, div_rem_r, mem_st_r;
  logic                div_busy, div_pulse, div_done_q, div_done, div_start;
  logic [31:0]         div_quo, div_rem;
  logic                load_in, transfer;

  // The divider only pulses done; keep it sticky until the instruction leaves.
  assign div_done  = div_pulse | div_done_q;
  assign ready_go  = valid & (~div_en_r | div_done);
  assign transfer  = ready_go & MEM_allow_in;
  assign allow_in  = ~valid | transfer;
  assign load_in   = ready_go_id & allow_in;
  assign div_start = valid & div_en_r & ~div_busy & ~div_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid        <= 1'b0;
      div_done_q   <= 1'b0;
      inst_exe     <= 32'd0;
      pc_exe       <= 32'd0;
      alu_op_r     <= '0;
      src1_r       <= 32'd0;
      src2_r       <= 32'd0;
      div_en_r     <= 1'b0;
      div_signed_r <= 1'b0;
      div_rem_r    <= 1'b0;
      reg_en       <= 1'b0;
      mem_ld       <= 1'b0;
      mem_st_r     <= 1'b0;
      st_data_r    <= 32'd0;
      dest         <= 5'd0;
    end else begin
      if (load_in)       valid <= 1'b1;
      else if (transfer) valid <= 1'b0;

      // Clearing on transfer lets a back-to-back DIV start fresh in its cycle 0.
      if (transfer)       div_done_q <= 1'b0;
      else if (div_pulse) div_done_q <= 1'b1;

      if (load_in) begin
        inst_exe     <= inst_from_id;
        pc_exe       <= pc_from_id;
        alu_op_r     <= alu_op_from_id;
        src1_r       <= src1_from_id;
        src2_r       <= src2_from_id;
        div_en_r     <= div_en_from_id;
        div_signed_r <= div_signed_from_id;
        div_rem_r    <= div_rem_from_id;
        reg_en       <= reg_en_from_id;
        mem_ld       <= mem_ld_from_id;
        mem_st_r     <= mem_st_from_id;
        st_data_r    <= st_data_from_id;
        dest         <= dest_from_id;
      end
    end
  end

  alu u_alu (
    .alu_op (alu_op_r),
    .src1   (src1_r),
    .src2   (src2_r),
    .result (alu_result)
  );

  div_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .is_signed (div_signed_r),
    .a         (src1_r),
    .b         (src2_r),
    .busy      (div_busy),
    .done      (div_pulse),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign exe_result       = div_en_r ? (div_rem_r ? div_rem : div_quo) : alu_result;
  assign forward_data_exe = exe_result;
  assign exe_is_load      = valid & mem_ld;

  // Request only in the transfer cycle so a MEM stall never repeats it.
  assign data_sram_en    = valid & (mem_ld | mem_st_r) & transfer;
  assign data_sram_we    = {4{data_sram_en & mem_st_r}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = st_data_r;

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;
  import cpu_defs::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                ready_go_id;
  logic                allow_in;
  logic [31:0]         inst_from_id, pc_from_id, src1_from_id, src2_from_id, st_data_from_id;
  logic [ALU_OP_W-1:0] alu_op_from_id;
  logic                div_en_from_id, div_signed_from_id, div_rem_from_id;
  logic                reg_en_from_id, mem_ld_from_id, mem_st_from_id;
  logic [4:0]          dest_from_id;
  logic                ready_go, MEM_allow_in;
  logic [31:0]         inst_exe, pc_exe, exe_result, data_sram_addr, data_sram_wdata, forward_data_exe;
  logic                reg_en, mem_ld, data_sram_en, valid, exe_is_load;
  logic [4:0]          dest;
  logic [3:0]          data_sram_we;

  int vectors = 0;
  int errors  = 0;

  exe_stage dut (
    .clk(clk), .reset(reset), .ready_go_id(ready_go_id), .allow_in(allow_in),
    .inst_from_id(inst_from_id), .pc_from_id(pc_from_id), .alu_op_from_id(alu_op_from_id),
    .src1_from_id(src1_from_id), .src2_from_id(src2_from_id),
    .div_en_from_id(div_en_from_id), .div_signed_from_id(div_signed_from_id),
    .div_rem_from_id(div_rem_from_id), .reg_en_from_id(reg_en_from_id),
    .mem_ld_from_id(mem_ld_from_id), .mem_st_from_id(mem_st_from_id),
    .st_data_from_id(st_data_from_id), .dest_from_id(dest_from_id),
    .ready_go(ready_go), .MEM_allow_in(MEM_allow_in), .inst_exe(inst_exe), .pc_exe(pc_exe),
    .reg_en(reg_en), .mem_ld(mem_ld), .dest(dest), .exe_result(exe_result),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .valid(valid), .forward_data_exe(forward_data_exe), .exe_is_load(exe_is_load)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one instruction for a single cycle; caller guarantees allow_in.
  task automatic issue(input int op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic de, input logic ds, input logic dr,
                       input logic ld, input logic st, input logic [31:0] sd);
    ready_go_id        = 1'b1;
    alu_op_from_id     = '0;
    alu_op_from_id[op] = 1'b1;
    src1_from_id       = s1;
    src2_from_id       = s2;
    div_en_from_id     = de;
    div_signed_from_id = ds;
    div_rem_from_id    = dr;
    mem_ld_from_id     = ld;
    mem_st_from_id     = st;
    st_data_from_id    = sd;
    @(negedge clk);
    ready_go_id = 1'b0;
  endtask

  // Waits (bounded) for ready_go; returns the cycle index it first appeared on.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (ready_go !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic rem,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int cyc;
    issue(OP_ADD, a, b, 1'b1, sgn, rem, 1'b0, 1'b0, 32'd0);
    wait_ready(cyc);
    chk({tag, "_lat"}, 32'(cyc), 32'd33);
    chk({tag, "_res"}, exe_result, exp);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; ready_go_id = 1'b0; MEM_allow_in = 1'b1;
    inst_from_id = 32'h0; pc_from_id = 32'h0; alu_op_from_id = '0;
    src1_from_id = 32'h0; src2_from_id = 32'h0; st_data_from_id = 32'h0;
    div_en_from_id = 1'b0; div_signed_from_id = 1'b0; div_rem_from_id = 1'b0;
    reg_en_from_id = 1'b0; mem_ld_from_id = 1'b0; mem_st_from_id = 1'b0; dest_from_id = 5'd0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_allow_in", 32'(allow_in), 32'd1);
    chk("rst_ready_go", 32'(ready_go), 32'd0);
    chk("rst_sram_en", 32'(data_sram_en), 32'd0);
    chk("rst_sram_we", 32'(data_sram_we), 32'd0);
    chk("rst_result", exe_result, 32'd0);
    reset = 1'b0;

    // ADD 5+7, MEM ready
    inst_from_id = 32'h0085_3021; pc_from_id = 32'hBFC0_0010;
    reg_en_from_id = 1'b1; dest_from_id = 5'd6;
    issue(OP_ADD, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("add_valid", 32'(valid), 32'd1);
    chk("add_result", exe_result, 32'd12);
    chk("add_fwd", forward_data_exe, 32'd12);
    chk("add_ready_go", 32'(ready_go), 32'd1);
    chk("add_pc", pc_exe, 32'hBFC0_0010);
    chk("add_inst", inst_exe, 32'h0085_3021);
    chk("add_dest", 32'(dest), 32'd6);
    chk("add_reg_en", 32'(reg_en), 32'd1);
    chk("add_no_sram", 32'(data_sram_en), 32'd0);
    @(negedge clk);
    chk("add_left", 32'(valid), 32'd0);

    // A few more ALU ops
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("slt", exe_result, 32'd1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("sltu", exe_result, 32'd0);
    issue(OP_SRA, 32'd4, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("sra", exe_result, 32'hF800_0000);
    issue(OP_LUI, 32'd0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("lui", exe_result, 32'h1234_0000);
    issue(OP_NOR, 32'h0F0F_0000, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("nor", exe_result, 32'hF0F0_FF00);
    @(negedge clk);

    // Store 0x10+0x0C with MEM stalled two cycles
    MEM_allow_in = 1'b0; reg_en_from_id = 1'b0;
    issue(OP_ADD, 32'h10, 32'h0C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("st_stall1_en", 32'(data_sram_en), 32'd0);
    chk("st_stall1_allow", 32'(allow_in), 32'd0);
    @(negedge clk);
    chk("st_stall2_en", 32'(data_sram_en), 32'd0);
    MEM_allow_in = 1'b1;
    #1;
    chk("st_xfer_en", 32'(data_sram_en), 32'd1);
    chk("st_xfer_we", 32'(data_sram_we), 32'hF);
    chk("st_xfer_addr", data_sram_addr, 32'h1C);
    chk("st_xfer_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("st_after_en", 32'(data_sram_en), 32'd0);
    chk("st_after_valid", 32'(valid), 32'd0);

    // Signed DIV -7/2
    run_div("div_m7_2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    chk("div_left", 32'(valid), 32'd0);

    // Signed MOD -7/2 held by MEM, then a back-to-back DIVU 7/0
    MEM_allow_in = 1'b0;
    issue(OP_ADD, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    wait_ready(cyc);
    chk("mod_lat", 32'(cyc), 32'd33);
    repeat (3) @(negedge clk);
    chk("mod_hold_rdy", 32'(ready_go), 32'd1);
    chk("mod_hold_res", exe_result, 32'hFFFF_FFFF);
    MEM_allow_in = 1'b1;
    issue(OP_ADD, 32'd7, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("b2b_cycle0_valid", 32'(valid), 32'd1);
    chk("b2b_cycle0_rdy", 32'(ready_go), 32'd0);
    wait_ready(cyc);
    chk("divu_7_0_lat", 32'(cyc), 32'd33);
    chk("divu_7_0_q", exe_result, 32'hFFFF_FFFF);
    @(negedge clk);

    // Divide-by-zero remainder and signed overflow
    run_div("modu_7_0", 1'b0, 1'b1, 32'd7, 32'd0, 32'd7);
    run_div("div_s7_0", 1'b1, 1'b0, 32'd7, 32'd0, 32'hFFFF_FFFF);
    run_div("div_ovf_q", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("div_ovf_r", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_div("divu_big", 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);

    // Load entering while MEM is stalled
    MEM_allow_in = 1'b0;
    issue(OP_ADD, 32'h100, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    chk("ld_is_load", 32'(exe_is_load), 32'd1);
    chk("ld_allow_in", 32'(allow_in), 32'd0);
    chk("ld_stall_en", 32'(data_sram_en), 32'd0);
    @(negedge clk);
    chk("ld_stall2_en", 32'(data_sram_en), 32'd0);
    MEM_allow_in = 1'b1;
    #1;
    chk("ld_xfer_en", 32'(data_sram_en), 32'd1);
    chk("ld_xfer_we", 32'(data_sram_we), 32'd0);
    chk("ld_xfer_addr", data_sram_addr, 32'h104);
    @(negedge clk);
    chk("ld_after_is_load", 32'(exe_is_load), 32'd0);

    // Reset in cycle 10 of a divide
    issue(OP_ADD, 32'd100, 32'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstdiv_valid", 32'(valid), 32'd0);
    chk("rstdiv_ready_go", 32'(ready_go), 32'd0);
    chk("rstdiv_allow_in", 32'(allow_in), 32'd1);
    issue(OP_ADD, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("rstdiv_add_res", exe_result, 32'd7);
    chk("rstdiv_add_rdy", 32'(ready_go), 32'd1);
    @(negedge clk);
    run_div("div_after_rst", 1'b1, 1'b0, 32'd100, 32'd3, 32'd33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order pipeline, between ID and MEM.
- Latches the ID bundle under the valid/allow_in handshake and computes the ALU result.
- Runs an iterative 32-bit divider (DIV/MOD, signed/unsigned) that stalls the stage while busy.
- Issues the word-sized data SRAM request so read data arrives while the instruction sits in MEM; exports forward data and a load flag to ID for bypass and load-use interlock.

Parameters:
- ALU_OP_W, 12, width of the one-hot ALU op vector; value comes from the shared package.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ready_go_id  in  1  ID holds a valid instruction ready to move
- allow_in  out  1  EXE can accept an instruction this cycle
- inst_from_id  in  32  instruction word
- pc_from_id  in  32  PC
- alu_op_from_id  in  ALU_OP_W  one-hot ALU operation
- src1_from_id  in  32  operand 1, already bypassed
- src2_from_id  in  32  operand 2, already bypassed
- div_en_from_id  in  1  instruction is DIV/MOD
- div_signed_from_id  in  1  signed division
- div_rem_from_id  in  1  result is remainder, not quotient
- reg_en_from_id  in  1  writes the register file
- mem_ld_from_id  in  1  word load
- mem_st_from_id  in  1  word store
- st_data_from_id  in  32  store data
- dest_from_id  in  5  destination register
- ready_go  out  1  EXE result is complete
- MEM_allow_in  in  1  MEM accepts
- inst_exe  out  32  latched instruction
- pc_exe  out  32  latched PC
- reg_en  out  1  latched register write enable
- mem_ld  out  1  latched load flag
- dest  out  5  latched destination
- exe_result  out  32  ALU result, or divider result when div_en
- data_sram_en  out  1  data SRAM request
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  address (= ALU result)
- data_sram_wdata  out  32  store data
- valid  out  1  EXE holds an instruction
- forward_data_exe  out  32  equals exe_result
- exe_is_load  out  1  valid & mem_ld, used for load-use stall in ID

Behaviour:
- Reset: valid=0; all bundle registers=0; divider idle; count=0; div_done=0. Hence data_sram_en=0, we=0, ready_go=0, allow_in=1.
- Valid update, in priority order:
  - reset → 0
  - ready_go_id & allow_in → 1
  - ready_go & MEM_allow_in → 0
  - otherwise hold
- Bundle capture: registers load only on ready_go_id & allow_in.
- allow_in = ~valid | (ready_go & MEM_allow_in).
- ready_go = valid & (~div_en_reg | div_done).
- ALU: combinational from the latched ops; single cycle.
- SRAM request:
  - data_sram_en = valid & (mem_ld|mem_st) & ready_go & MEM_allow_in, so it fires only in the transfer cycle and is never repeated during a stall.
  - data_sram_we = {4{data_sram_en & mem_st}}.
- Divider latency (cycle 0 = first cycle valid with div_en_reg):
  - Cycle 0: start pulse; captures |src1|, |src2| (absolute value only when signed) and the result signs.
  - Cycles 1..32: one restoring iteration per cycle; count runs 1→32.
  - Cycle 33: registered result, sign-corrected, is available; div_done=1 and ready_go=1.
  - div_done stays 1 until the instruction leaves EXE, then clears in the same edge that loads the next instruction.
- Back-to-back DIVs: the second starts in its own cycle 0, which is the cycle after the transfer.
- Divide by zero: unsigned gives q=0xFFFFFFFF, r=dividend. Signed applies the sign correction to those values (7/0 → q=0xFFFFFFFF, r=7).
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0.
- Remainder sign follows the dividend; quotient sign = sign1 ^ sign2.
- MEM stall while div_done=1: result and outputs hold; no re-start.
- Reset mid-divide: divider aborts; count=0, done=0, valid=0 on the next edge.
- Non-div instructions never start the divider.

Decomposition:
- Shared package cpu_defs:
  - ALU_OP_W and the one-hot op bit indices (add, sub, slt, sltu, and, or, nor, xor, sll, srl, sra, lui)
  - DIV_ITER=32
- Existing combinational alu module is instantiated unchanged.
- Sub-module div_iter:
  - inputs: clk, reset, start, signed, a, b
  - outputs: busy, done, quotient, remainder; contains the counter and the shift-subtract datapath.

Test Plan:
- ADD with src1=5, src2=7, MEM_allow_in=1 → exe_result=12 and ready_go=1 in the first EXE cycle; instruction transfers the next edge.
- Store, addr 0x1C, data 0xDEADBEEF, MEM_allow_in low for 2 cycles → data_sram_en/we=0xF asserted exactly once, in the transfer cycle, with addr 0x1C and wdata 0xDEADBEEF.
- Signed DIV −7/2 → ready_go low for cycles 0–32, high at cycle 33; q=0xFFFFFFFD. MOD variant gives r=0xFFFFFFFF.
- Edge cases: DIVU 7/0 → q=0xFFFFFFFF, r=7. DIV 0x80000000/0xFFFFFFFF → q=0x80000000, r=0.
- Load entering with MEM_allow_in=0 → exe_is_load=1 while held, allow_in=0, no SRAM request until MEM_allow_in=1.
- Reset at cycle 10 of a divide → valid=0, ready_go=0, allow_in=1 next cycle; a following ADD completes normally.
